// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Iterative shift/rotate sequencer shared by two requesters (port 0: EX-stage
//   ALU, port 1: aux/debug). A round-robin arbiter accepts one operation at a
//   time. The operation is processed at most STEP bit positions per cycle, and
//   the result is returned with the winning requester's id over a valid/ready
//   handshake.
//
// Parameters
//   DATA_W  data width (fixed at 16; the amount field is 4 bits)
//   STEP    max bit positions per RUN cycle (1, 2, 4 or 8)
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   reqN_valid/reqN_ready request handshake for port N (ready is combinational)
//   reqN_op               00 SLL, 01 SRA, 10 ROR, 11 pass-through
//   reqN_data, reqN_amt   operand and shift/rotate amount (0..15)
//   res_valid/res_ready   result handshake
//   res_data, res_id      result value and the id of the requester that issued it
//   busy                  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int STEP   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [3:0]        req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [3:0]        req1_amt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_ROR  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  localparam logic [3:0] STEP_AMT = 4'(STEP);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        rem_q, rem_d;
  logic              id_q, id_d;
  logic              rr_q, rr_d;     // port that wins when both request

  logic              any_valid;
  logic              grant;
  op_e               sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        sel_amt;
  logic [3:0]        step_amt;
  logic [DATA_W-1:0] step_res;

  // Arbitration: a lone requester always wins; on contention the pointer decides.
  assign any_valid = req0_valid | req1_valid;
  assign grant     = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign sel_op    = op_e'(grant ? req1_op : req0_op);
  assign sel_data  = grant ? req1_data : req0_data;
  assign sel_amt   = grant ? req1_amt  : req0_amt;

  // One RUN step: move by min(rem, STEP) positions.
  always_comb begin
    step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    unique case (op_q)
      OP_SLL:  step_res = data_q << step_amt;
      OP_SRA:  step_res = DATA_W'($signed(data_q) >>> step_amt);
      // Shifting the doubled word right leaves the rotated value in the low half.
      OP_ROR:  step_res = DATA_W'({data_q, data_q} >> step_amt);
      default: step_res = data_q;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    rem_d      = rem_q;
    id_d       = id_q;
    rr_d       = rr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          req0_ready = req0_valid & ~grant;
          req1_ready = req1_valid & grant;
          op_d       = sel_op;
          data_d     = sel_data;
          rem_d      = sel_amt;
          id_d       = grant;
          rr_d       = ~grant;
          // Nothing to iterate for a zero amount or a pass-through.
          state_d    = (sel_amt == 4'd0 || sel_op == OP_PASS) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        data_d = step_res;
        rem_d  = rem_q - step_amt;
        if (rem_q <= STEP_AMT) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      data_q  <= '0;
      rem_q   <= '0;
      id_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign res_data  = data_q;
  assign res_id    = id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
//   Self-checking bench for shift_seq_ctrl. Four instances run side by side
//   with STEP = 1, 2, 4 and 8 (instance k uses STEP = 1 << k). Directed
//   scenarios run on the STEP=4 instance. A randomized sweep runs on every
//   instance and is compared against a bit-at-a-time reference model that
//   includes round-robin arbitration.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRA  = 2'b01;
  localparam logic [1:0] ROR  = 2'b10;
  localparam logic [1:0] PASS = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0v[4], r0r[4], r1v[4], r1r[4];
  logic [1:0]  r0op[4], r1op[4];
  logic [15:0] r0d[4], r1d[4], rsd[4];
  logic [3:0]  r0a[4], r1a[4];
  logic        rsv[4], rsr[4], rid[4], bsy[4];

  int tests = 0;
  int fails = 0;
  int ptr[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    shift_seq_ctrl #(.DATA_W(16), .STEP(1 << g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (r0v[g]),
      .req0_ready (r0r[g]),
      .req0_op    (r0op[g]),
      .req0_data  (r0d[g]),
      .req0_amt   (r0a[g]),
      .req1_valid (r1v[g]),
      .req1_ready (r1r[g]),
      .req1_op    (r1op[g]),
      .req1_data  (r1d[g]),
      .req1_amt   (r1a[g]),
      .res_valid  (rsv[g]),
      .res_ready  (rsr[g]),
      .res_data   (rsd[g]),
      .res_id     (rid[g]),
      .busy       (bsy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: apply the operation one bit position at a time, amt times.
  function automatic logic [15:0] model(input logic [1:0] op, input logic [15:0] d, input int amt);
    logic [15:0] r;
    r = d;
    if (op == PASS) return d;
    for (int i = 0; i < amt; i++) begin
      case (op)
        SLL:     r = {r[14:0], 1'b0};
        SRA:     r = {r[15], r[15:1]};
        ROR:     r = {r[0], r[15:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input int k, input logic [1:0] op, input logic [3:0] a);
    int step;
    step = 1 << k;
    if (op == PASS || a == 4'd0) return 1;
    return 1 + (int'(a) + step - 1) / step;
  endfunction

  function automatic logic rdy(input int k, input int port);
    return (port != 0) ? r1r[k] : r0r[k];
  endfunction

  task automatic drive(input int k, input int port, input logic v, input logic [1:0] op,
                       input logic [15:0] d, input logic [3:0] a);
    if (port == 0) begin
      r0v[k] = v; r0op[k] = op; r0d[k] = d; r0a[k] = a;
    end else begin
      r1v[k] = v; r1op[k] = op; r1d[k] = d; r1a[k] = a;
    end
  endtask

  task automatic set_valid(input int k, input int port, input logic v);
    if (port == 0) r0v[k] = v;
    else           r1v[k] = v;
  endtask

  // Count edges from the accept edge (inclusive) until res_valid is seen.
  task automatic wait_res(input int k, output int lat);
    lat = 1;
    while (!rsv[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("res_valid_seen", 32'(rsv[k]), 32'd1);
  endtask

  task automatic handoff(input int k);
    @(negedge clk);
    rsr[k] = 1'b1;
    @(posedge clk); #1;
    rsr[k] = 1'b0;
    check("res_valid_after_handoff", 32'(rsv[k]), 32'd0);
    check("busy_after_handoff", 32'(bsy[k]), 32'd0);
  endtask

  // Issue one operation from a single port and check data, id and latency.
  task automatic run_op(input int k, input int port, input logic [1:0] op,
                        input logic [15:0] d, input logic [3:0] a, input bit do_handoff);
    int w;
    int lat;
    @(negedge clk);
    drive(k, port, 1'b1, op, d, a);
    #1;
    w = 0;
    while (!rdy(k, port) && w < 50) begin
      @(negedge clk); #1;
      w++;
    end
    check("accept", 32'(w < 50), 32'd1);
    @(posedge clk); #1;
    set_valid(k, port, 1'b0);
    wait_res(k, lat);
    check("latency", lat, model_lat(k, op, a));
    check("res_data", 32'(rsd[k]), 32'(model(op, d, int'(a))));
    check("res_id", 32'(rid[k]), port);
    if (do_handoff) handoff(k);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int mask;
    int g;
    logic [1:0]  rop[2];
    logic [15:0] rd[2];
    logic [3:0]  ra[2];

    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(k, 0, 1'b0, SLL, 16'h0, 4'h0);
      drive(k, 1, 1'b0, SLL, 16'h0, 4'h0);
      rsr[k] = 1'b0;
      ptr[k] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_res_valid", 32'(rsv[k]), 32'd0);
      check("rst_busy", 32'(bsy[k]), 32'd0);
      check("rst_res_data", 32'(rsd[k]), 32'd0);
      check("rst_res_id", 32'(rid[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ---- contention twice in a row: grants 0 then 1 ----
    @(negedge clk);
    drive(2, 0, 1'b1, PASS, 16'hBEEF, 4'd0);
    drive(2, 1, 1'b1, PASS, 16'h5A5A, 4'd0);
    #1;
    check("arb1_ready0", 32'(r0r[2]), 32'd1);
    check("arb1_ready1", 32'(r1r[2]), 32'd0);
    @(posedge clk); #1;
    set_valid(2, 0, 1'b0);
    wait_res(2, lat);
    check("arb1_lat", lat, 1);
    check("arb1_id", 32'(rid[2]), 32'd0);
    check("arb1_data", 32'(rsd[2]), 32'hBEEF);
    check("arb1_done_ready1", 32'(r1r[2]), 32'd0);
    handoff(2);
    @(negedge clk);
    set_valid(2, 0, 1'b1);
    #1;
    check("arb2_ready0", 32'(r0r[2]), 32'd0);
    check("arb2_ready1", 32'(r1r[2]), 32'd1);
    @(posedge clk); #1;
    set_valid(2, 0, 1'b0);
    set_valid(2, 1, 1'b0);
    wait_res(2, lat);
    check("arb2_id", 32'(rid[2]), 32'd1);
    check("arb2_data", 32'(rsd[2]), 32'h5A5A);
    handoff(2);

    // ---- ROR then consumer stall for 10 cycles ----
    run_op(2, 0, ROR, 16'h1234, 4'd4, 1'b0);
    check("ror_const", 32'(rsd[2]), 32'h4123);
    @(negedge clk);
    drive(2, 0, 1'b1, SLL, 16'h0001, 4'd3);
    drive(2, 1, 1'b1, SRA, 16'h8000, 4'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("stall_valid", 32'(rsv[2]), 32'd1);
      check("stall_data", 32'(rsd[2]), 32'h4123);
      check("stall_id", 32'(rid[2]), 32'd0);
      check("stall_ready0", 32'(r0r[2]), 32'd0);
      check("stall_ready1", 32'(r1r[2]), 32'd0);
      check("stall_busy", 32'(bsy[2]), 32'd1);
    end
    set_valid(2, 0, 1'b0);
    set_valid(2, 1, 1'b0);
    handoff(2);

    // ---- boundary amounts and pass-through ----
    run_op(2, 1, SRA, 16'h8000, 4'd15, 1'b0);
    check("sra15_const", 32'(rsd[2]), 32'hFFFF);
    handoff(2);
    run_op(2, 0, SLL, 16'h0001, 4'd15, 1'b0);
    check("sll15_const", 32'(rsd[2]), 32'h8000);
    handoff(2);
    run_op(2, 1, ROR, 16'hBEEF, 4'd0, 1'b0);
    check("amt0_const", 32'(rsd[2]), 32'hBEEF);
    handoff(2);
    run_op(2, 0, PASS, 16'hBEEF, 4'd7, 1'b0);
    check("pass_const", 32'(rsd[2]), 32'hBEEF);
    handoff(2);

    // ---- reset in the middle of RUN ----
    @(negedge clk);
    drive(2, 0, 1'b1, ROR, 16'hF00F, 4'd12);
    #1;
    check("mid_accept", 32'(r0r[2]), 32'd1);
    @(posedge clk); #1;
    set_valid(2, 0, 1'b0);
    @(posedge clk); #1;
    check("mid_busy", 32'(bsy[2]), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsv[2]), 32'd0);
    check("mid_rst_busy", 32'(bsy[2]), 32'd0);
    check("mid_rst_data", 32'(rsd[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(2, 0, 1'b1, PASS, 16'h1111, 4'd0);
    drive(2, 1, 1'b1, PASS, 16'h2222, 4'd0);
    #1;
    check("rst_ptr_ready0", 32'(r0r[2]), 32'd1);
    check("rst_ptr_ready1", 32'(r1r[2]), 32'd0);
    #1;
    set_valid(2, 0, 1'b0);
    set_valid(2, 1, 1'b0);
    run_op(2, 1, ROR, 16'hF00F, 4'd12, 1'b1);

    // ---- randomized sweep on every STEP, including contention ----
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) ptr[k] = 0;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 40; n++) begin
        mask = int'($urandom_range(1, 3));
        for (int p = 0; p < 2; p++) begin
          rop[p] = 2'($urandom_range(0, 3));
          rd[p]  = 16'($urandom);
          ra[p]  = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        for (int p = 0; p < 2; p++)
          if (mask[p]) drive(k, p, 1'b1, rop[p], rd[p], ra[p]);
        while (mask != 0) begin
          #1;
          g = (mask == 3) ? ptr[k] : ((mask == 2) ? 1 : 0);
          check("rnd_grant", 32'(rdy(k, g)), 32'd1);
          check("rnd_other", 32'(rdy(k, 1 - g)), 32'd0);
          @(posedge clk); #1;
          set_valid(k, g, 1'b0);
          mask = mask & ~(1 << g);
          ptr[k] = 1 - g;
          wait_res(k, lat);
          check("rnd_lat", lat, model_lat(k, rop[g], ra[g]));
          check("rnd_data", 32'(rsd[k]), 32'(model(rop[g], rd[g], int'(ra[g]))));
          check("rnd_id", 32'(rid[k]), g);
          handoff(k);
          @(negedge clk);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
